cmsdk_ahb_matrix_decoder_p: RTL and testbench
=============================================

CMSDK_AHB_MATRIX_DECODER_P -- requirements
Module: cmsdk_ahb_matrix_decoder_p

Interface
REQ-001 SHALL have parameter NUM_MI, default 3, number of output ports, range 1..8.
REQ-002 SHALL have parameter NUM_REGIONS, default 4, number of address regions, range 1..8.
REQ-003 SHALL have parameter REGION_START, default all zero, packed NUM_REGIONS x 22-bit inclusive lower bounds on HADDR[31:10].
REQ-004 SHALL have parameter REGION_END, default all zero, packed NUM_REGIONS x 22-bit inclusive upper bounds.
REQ-005 SHALL have parameter REGION_PORT, default all zero, packed NUM_REGIONS x 3-bit target port index.
REQ-006 SHALL have parameter REGION_REMAP, default 0, NUM_REGIONS bits; bit set means the region is valid only while remapping_dec=1.
REQ-007 SHALL have parameters DATA_W, default 32, and USER_W, default 32.
REQ-008 SHALL use one clock and an asynchronous, active-low reset, named HCLK and HRESETn.
REQ-009 HCLK  in  1  AHB system clock.
REQ-010 HRESETn  in  1  async active-low reset.
REQ-011 remapping_dec  in  1  remap control.
REQ-012 HREADYS  in  1  input-stage transfer done.
REQ-013 sel_dec  in  1  HSEL from input stage.
REQ-014 decode_addr_dec  in  22  HADDR[31:10].
REQ-015 trans_dec  in  2  HTRANS.
REQ-016 active_dec_v  in  NUM_MI  per-port active flags.
REQ-017 readyout_dec_v  in  NUM_MI  per-port HREADYOUT.
REQ-018 resp_dec_v  in  2*NUM_MI  per-port HRESP, port i at [2i+1:2i].
REQ-019 rdata_dec_v  in  DATA_W*NUM_MI; ruser_dec_v  in  USER_W*NUM_MI  per-port read data and user data.
REQ-020 sel_dec_v  out  NUM_MI  one-hot port select.
REQ-021 active_dec  out  1; HREADYOUTS  out  1; HRESPS  out  2; HRDATAS  out  DATA_W; HRUSERS  out  USER_W.
REQ-022 err_clr  in  1; err_valid  out  1; err_addr  out  22.
- These three ports SHALL be present only with the macro in REQ-039.

Function
REQ-023 Address port selection SHALL be combinational:
- Select the lowest-index region with START<=addr<=END whose REMAP bit is 0, or whose REMAP bit is 1 while remapping_dec=1.
- If no region matches, select the default slave, encoded as index NUM_MI.
REQ-024 IDLE hold: when trans_dec=IDLE and data_out_port is not the default slave, addr_out_port SHALL equal data_out_port, overriding the region table.
REQ-025 REGION_PORT values >= NUM_MI SHALL decode to the default slave.
REQ-026 sel_dec_v[p] SHALL be 1 only when sel_dec=1 and addr_out_port=p; all bits SHALL be 0 when sel_dec=0.
REQ-027 active_dec SHALL equal active_dec_v[addr_out_port], or 1 when the default slave is selected.
REQ-028 data_out_port SHALL load addr_out_port on a rising HCLK edge when HREADYS=1, and hold otherwise.
REQ-029 HREADYOUTS, HRESPS, HRDATAS and HRUSERS SHALL be muxed from data_out_port with zero latency.
- Default slave: HRDATAS=0, HRUSERS=0.
REQ-030 The default slave SHALL be an internal FSM with states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-031 Default slave transitions:
- DS_IDLE->DS_ERR1 when the default slave is selected (sel_dec=1), trans_dec is NONSEQ or SEQ, and HREADYS=1.
- DS_ERR1->DS_ERR2 unconditionally.
- DS_ERR2->DS_ERR1 on a further qualifying transfer; otherwise DS_ERR2->DS_IDLE.
REQ-032 Default slave outputs:
- DS_IDLE: readyout=1, resp=00.
- DS_ERR1: readyout=0, resp=01.
- DS_ERR2: readyout=1, resp=01.
REQ-033 IDLE or BUSY transfers to the default slave SHALL receive a zero-wait OKAY.
REQ-034 With HREADYS=0, the FSM and data_out_port SHALL hold; a default-slave select SHALL NOT start an error sequence.

Reset
REQ-035 HRESETn low SHALL asynchronously set:
- data_out_port=0 (MI0);
- default slave FSM=DS_IDLE;
- err_valid=0, err_addr=0.
REQ-036 Immediately after reset, while data_out_port=0:
- HREADYOUTS=readyout_dec_v[0];
- HRESPS=resp_dec_v[1:0];
- HRDATAS=rdata_dec_v[0].
REQ-037 Reset asserted during DS_ERR1 SHALL abandon the error sequence; no ERROR is emitted after reset release.
REQ-038 All state SHALL be reset; there SHALL be no synchronous reset path.

Configuration
REQ-039 Macro CMSDK_DECODER_ERR_CAPTURE_EN defined: an error capture register SHALL be built in.
- On each DS_IDLE->DS_ERR1 transition with err_valid=0: capture decode_addr_dec into err_addr and set err_valid.
- While err_valid=1: first error is sticky, err_addr does not change.
- err_clr=1 clears err_valid on the next edge.
- Simultaneous err_clr and a new capture: the capture wins, err_valid=1 with the new address.
REQ-040 Macro undefined: the err_* ports and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-041 Default params, after reset, NONSEQ to 0x0000_1000 with HREADYS=1 -> sel_dec_v=001; next cycle HRDATAS=rdata from MI0.
REQ-042 remapping_dec=1, REMAP region0 = 0x000..0x03F -> MI1, NONSEQ to 0x0000_0400 -> sel_dec_v=010; with remapping_dec=0 -> 001.
REQ-043 NONSEQ to an unmapped 0xF000_0000 -> data cycle 1: HREADYOUTS=0, HRESPS=01; cycle 2: HREADYOUTS=1, HRESPS=01; cycle 3: OKAY.
REQ-044 IDLE to 0xF000_0000 while data_out_port=2 -> sel_dec_v=100 (hold), zero-wait OKAY from MI2.
REQ-045 HREADYS=0 for 3 cycles during a port change -> data_out_port holds; the muxed response stays from the old port until HREADYS=1.
REQ-046 Macro defined: two unmapped NONSEQs 0xF000_0000 then 0xE000_0000 -> err_addr=22'h3C0000; err_clr together with a third error -> err_addr updated and err_valid=1.

Source files
------------

// File: rtl/cmsdk_ahb_matrix_decoder_p.sv
//==============================================================================
// Module   : cmsdk_ahb_matrix_decoder_p
// Brief    : AHB matrix output-port decoder with region table, response mux
//            and internal default slave. Optional error capture register via
//            macro CMSDK_DECODER_ERR_CAPTURE_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cmsdk_ahb_matrix_decoder_p #(
    parameter int                           NUM_MI       = 3,
    parameter int                           NUM_REGIONS  = 4,
    parameter logic [NUM_REGIONS*22-1:0]    REGION_START = '0,
    parameter logic [NUM_REGIONS*22-1:0]    REGION_END   = '0,
    parameter logic [NUM_REGIONS*3-1:0]     REGION_PORT  = '0,
    parameter logic [NUM_REGIONS-1:0]       REGION_REMAP = '0,
    parameter int                           DATA_W       = 32,
    parameter int                           USER_W       = 32
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        remapping_dec,
    input  logic                        HREADYS,
    input  logic                        sel_dec,
    input  logic [21:0]                 decode_addr_dec,
    input  logic [1:0]                  trans_dec,
    input  logic [NUM_MI-1:0]           active_dec_v,
    input  logic [NUM_MI-1:0]           readyout_dec_v,
    input  logic [2*NUM_MI-1:0]         resp_dec_v,
    input  logic [DATA_W*NUM_MI-1:0]    rdata_dec_v,
    input  logic [USER_W*NUM_MI-1:0]    ruser_dec_v,
    output logic [NUM_MI-1:0]           sel_dec_v,
    output logic                        active_dec,
    output logic                        HREADYOUTS,
    output logic [1:0]                  HRESPS,
    output logic [DATA_W-1:0]           HRDATAS,
    output logic [USER_W-1:0]           HRUSERS
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
    ,
    input  logic                        err_clr,
    output logic                        err_valid,
    output logic [21:0]                 err_addr
`endif
);

    localparam logic [3:0] c_DEF_PORT = 4'(NUM_MI);

    localparam logic [1:0] c_DS_IDLE = 2'd0;
    localparam logic [1:0] c_DS_ERR1 = 2'd1;
    localparam logic [1:0] c_DS_ERR2 = 2'd2;

    logic [3:0] w_region_port;
    logic [3:0] w_addr_port;
    logic [3:0] r_data_port;
    logic       w_active;
    logic       w_ds_start;
    logic [1:0] r_ds_state;
    logic [1:0] w_ds_next;
    logic       w_ds_ready;
    logic [1:0] w_ds_resp;

    // Scan from the top so the lowest-index matching region wins.
    always_comb begin
        w_region_port = c_DEF_PORT;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((decode_addr_dec >= REGION_START[r*22 +: 22]) &&
                (decode_addr_dec <= REGION_END[r*22 +: 22]) &&
                (!REGION_REMAP[r] || remapping_dec)) begin
                if ({1'b0, REGION_PORT[r*3 +: 3]} < c_DEF_PORT) begin
                    w_region_port = {1'b0, REGION_PORT[r*3 +: 3]};
                end else begin
                    w_region_port = c_DEF_PORT;
                end
            end
        end
    end

    // IDLE transfers stay on the current data-phase slave.
    assign w_addr_port = ((trans_dec == 2'b00) && (r_data_port != c_DEF_PORT)) ?
                         r_data_port : w_region_port;

    generate
        for (genvar p = 0; p < NUM_MI; p++) begin : g_sel
            assign sel_dec_v[p] = sel_dec & (w_addr_port == 4'(p));
        end
    endgenerate

    always_comb begin
        w_active = 1'b1;
        for (int p = 0; p < NUM_MI; p++) begin
            if (w_addr_port == 4'(p)) begin
                w_active = active_dec_v[p];
            end
        end
    end

    assign active_dec = w_active;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_port <= 4'd0;
        end else if (HREADYS) begin
            r_data_port <= w_addr_port;
        end
    end

    always_comb begin
        HREADYOUTS = w_ds_ready;
        HRESPS     = w_ds_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int p = 0; p < NUM_MI; p++) begin
            if (r_data_port == 4'(p)) begin
                HREADYOUTS = readyout_dec_v[p];
                HRESPS     = resp_dec_v[2*p +: 2];
                HRDATAS    = rdata_dec_v[DATA_W*p +: DATA_W];
                HRUSERS    = ruser_dec_v[USER_W*p +: USER_W];
            end
        end
    end

    assign w_ds_start = sel_dec & (w_addr_port == c_DEF_PORT) & trans_dec[1] & HREADYS;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ds_state <= c_DS_IDLE;
        end else begin
            r_ds_state <= w_ds_next;
        end
    end

    // ERR1 is the wait cycle of the two-cycle ERROR response, so it never stalls.
    always_comb begin
        w_ds_next = r_ds_state;
        case (r_ds_state)
            c_DS_IDLE: if (w_ds_start) w_ds_next = c_DS_ERR1;
            c_DS_ERR1: w_ds_next = c_DS_ERR2;
            c_DS_ERR2: begin
                if (w_ds_start) begin
                    w_ds_next = c_DS_ERR1;
                end else if (HREADYS) begin
                    w_ds_next = c_DS_IDLE;
                end
            end
            default:   w_ds_next = c_DS_IDLE;
        endcase
    end

    always_comb begin
        w_ds_ready = 1'b1;
        w_ds_resp  = 2'b00;
        case (r_ds_state)
            c_DS_ERR1: begin
                w_ds_ready = 1'b0;
                w_ds_resp  = 2'b01;
            end
            c_DS_ERR2: begin
                w_ds_ready = 1'b1;
                w_ds_resp  = 2'b01;
            end
            default: begin
                w_ds_ready = 1'b1;
                w_ds_resp  = 2'b00;
            end
        endcase
    end

`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
    logic        r_err_valid;
    logic [21:0] r_err_addr;
    logic        w_capture;

    // A clear coinciding with a new error still records that new error.
    assign w_capture = (r_ds_state == c_DS_IDLE) && w_ds_start && (!r_err_valid || err_clr);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= 22'd0;
        end else if (w_capture) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= decode_addr_dec;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmsdk_ahb_matrix_decoder_p.sv
//==============================================================================
// Module   : tb_cmsdk_ahb_matrix_decoder_p
// Brief    : Directed table-driven bench for cmsdk_ahb_matrix_decoder_p.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_cmsdk_ahb_matrix_decoder_p;

    localparam int NUM_MI = 3;
    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_BUSY   = 2'b01;
    localparam logic [1:0] c_NONSEQ = 2'b10;
    localparam logic [1:0] c_SEQ    = 2'b11;

    logic                   HCLK = 1'b0;
    logic                   HRESETn;
    logic                   remapping_dec;
    logic                   HREADYS;
    logic                   sel_dec;
    logic [21:0]            decode_addr_dec;
    logic [1:0]             trans_dec;
    logic [NUM_MI-1:0]      active_dec_v;
    logic [NUM_MI-1:0]      readyout_dec_v;
    logic [2*NUM_MI-1:0]    resp_dec_v;
    logic [32*NUM_MI-1:0]   rdata_dec_v;
    logic [32*NUM_MI-1:0]   ruser_dec_v;
    logic [NUM_MI-1:0]      sel_dec_v;
    logic                   active_dec;
    logic                   HREADYOUTS;
    logic [1:0]             HRESPS;
    logic [31:0]            HRDATAS;
    logic [31:0]            HRUSERS;
    logic                   err_clr;
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
    logic                   err_valid;
    logic [21:0]            err_addr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cmsdk_ahb_matrix_decoder_p #(
        .NUM_MI       (NUM_MI),
        .NUM_REGIONS  (4),
        .REGION_START ({22'h000200, 22'h000100, 22'h000000, 22'h000000}),
        .REGION_END   ({22'h0002FF, 22'h0001FF, 22'h0000FF, 22'h00003F}),
        .REGION_PORT  ({3'd5, 3'd2, 3'd0, 3'd1}),
        .REGION_REMAP (4'b0001),
        .DATA_W       (32),
        .USER_W       (32)
    ) u_dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .remapping_dec   (remapping_dec),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_dec_v    (active_dec_v),
        .readyout_dec_v  (readyout_dec_v),
        .resp_dec_v      (resp_dec_v),
        .rdata_dec_v     (rdata_dec_v),
        .ruser_dec_v     (ruser_dec_v),
        .sel_dec_v       (sel_dec_v),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS)
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        ,
        .err_clr         (err_clr),
        .err_valid       (err_valid),
        .err_addr        (err_addr)
`endif
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [21:0] addr;
        logic        remap;
        logic [2:0]  exp_sel;
        logic        exp_act;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input logic s, input logic [1:0] t, input logic [21:0] a, input logic rdy);
        sel_dec         = s;
        trans_dec       = t;
        decode_addr_dec = a;
        HREADYS         = rdy;
    endtask

    // Unmapped NONSEQ with HREADYS following the two-cycle ERROR handshake.
    task automatic err_seq(input logic [21:0] a, input logic clr);
        drv(1'b1, c_NONSEQ, a, 1'b1);
        err_clr = clr;
        tick();
        err_clr = 1'b0;
        drv(1'b1, c_IDLE, a, 1'b0);
        #1;
        chk("err1_ready", HREADYOUTS, 1'b0);
        chk("err1_resp",  HRESPS,     2'b01);
        chk("err1_rdata", HRDATAS,    32'h0);
        chk("err1_ruser", HRUSERS,    32'h0);
        tick();
        drv(1'b1, c_IDLE, a, 1'b1);
        #1;
        chk("err2_ready", HREADYOUTS, 1'b1);
        chk("err2_resp",  HRESPS,     2'b01);
        tick();
        #1;
        chk("err_done_ready", HREADYOUTS, 1'b1);
        chk("err_done_resp",  HRESPS,     2'b00);
    endtask

    initial begin
        vecs[0]  = '{1'b1, c_NONSEQ, 22'h000004, 1'b0, 3'b001, 1'b1};
        vecs[1]  = '{1'b1, c_NONSEQ, 22'h000001, 1'b1, 3'b010, 1'b0};
        vecs[2]  = '{1'b1, c_NONSEQ, 22'h000001, 1'b0, 3'b001, 1'b1};
        vecs[3]  = '{1'b1, c_NONSEQ, 22'h000100, 1'b0, 3'b100, 1'b1};
        vecs[4]  = '{1'b1, c_NONSEQ, 22'h0001FF, 1'b0, 3'b100, 1'b1};
        vecs[5]  = '{1'b1, c_NONSEQ, 22'h000200, 1'b0, 3'b000, 1'b1};
        vecs[6]  = '{1'b1, c_NONSEQ, 22'h3C0000, 1'b0, 3'b000, 1'b1};
        vecs[7]  = '{1'b0, c_NONSEQ, 22'h000001, 1'b1, 3'b000, 1'b0};
        vecs[8]  = '{1'b1, c_IDLE,   22'h000100, 1'b0, 3'b001, 1'b1};
        vecs[9]  = '{1'b1, c_SEQ,    22'h0000FF, 1'b0, 3'b001, 1'b1};
        vecs[10] = '{1'b1, c_NONSEQ, 22'h000040, 1'b1, 3'b001, 1'b1};
        vecs[11] = '{1'b1, c_BUSY,   22'h3C0000, 1'b0, 3'b000, 1'b1};

        HRESETn        = 1'b0;
        remapping_dec  = 1'b0;
        err_clr        = 1'b0;
        drv(1'b0, c_IDLE, 22'h0, 1'b0);
        active_dec_v   = 3'b101;
        readyout_dec_v = 3'b110;
        resp_dec_v     = 6'b00_00_10;
        for (int p = 0; p < NUM_MI; p++) begin
            rdata_dec_v[32*p +: 32] = 32'hA0A0_0000 + p;
            ruser_dec_v[32*p +: 32] = 32'h5500_0000 + p;
        end

        // Reset state: data port is MI0.
        #12;
        chk("rst_ready", HREADYOUTS, 1'b0);
        chk("rst_resp",  HRESPS,     2'b10);
        chk("rst_rdata", HRDATAS,    32'hA0A0_0000);
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("rst_err_valid", err_valid, 1'b0);
        chk("rst_err_addr",  err_addr,  22'h0);
`endif
        tick();
        HRESETn        = 1'b1;
        readyout_dec_v = 3'b111;
        resp_dec_v     = 6'b0;
        tick();

        // Combinational address decode with the data phase parked on MI0.
        for (int i = 0; i < 12; i++) begin
            remapping_dec = vecs[i].remap;
            drv(vecs[i].sel, vecs[i].trans, vecs[i].addr, 1'b0);
            #1;
            chk($sformatf("vec%0d_sel", i), sel_dec_v,  vecs[i].exp_sel);
            chk($sformatf("vec%0d_act", i), active_dec, vecs[i].exp_act);
            chk($sformatf("vec%0d_rd",  i), HRDATAS,    32'hA0A0_0000);
        end
        remapping_dec = 1'b0;
        tick();

        // Move to MI2.
        drv(1'b1, c_NONSEQ, 22'h000100, 1'b1);
        #1;
        chk("mi2_sel", sel_dec_v, 3'b100);
        tick();
        drv(1'b0, c_IDLE, 22'h0, 1'b1);
        #1;
        chk("mi2_rdata", HRDATAS, 32'hA0A0_0002);
        chk("mi2_ruser", HRUSERS, 32'h5500_0002);

        // IDLE to an unmapped address holds on MI2.
        drv(1'b1, c_IDLE, 22'h3C0000, 1'b1);
        #1;
        chk("hold_sel",   sel_dec_v,  3'b100);
        chk("hold_ready", HREADYOUTS, 1'b1);
        chk("hold_resp",  HRESPS,     2'b00);
        tick();
        #1;
        chk("hold_rdata2", HRDATAS,    32'hA0A0_0002);
        chk("hold_ready2", HREADYOUTS, 1'b1);

        // NONSEQ to 0x0000_1000 lands on MI0.
        drv(1'b1, c_NONSEQ, 22'h000004, 1'b1);
        #1;
        chk("mi0_sel", sel_dec_v, 3'b001);
        tick();
        drv(1'b0, c_IDLE, 22'h0, 1'b1);
        #1;
        chk("mi0_rdata", HRDATAS, 32'hA0A0_0000);

        // Port change stalled by HREADYS=0.
        drv(1'b1, c_NONSEQ, 22'h000100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_rdata", k), HRDATAS, 32'hA0A0_0000);
        end
        HREADYS = 1'b1;
        tick();
        drv(1'b0, c_IDLE, 22'h0, 1'b1);
        #1;
        chk("stall_done_rdata", HRDATAS, 32'hA0A0_0002);

        // Default slave ERROR responses and capture register.
        err_seq(22'h3C0000, 1'b0);
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("cap1_valid", err_valid, 1'b1);
        chk("cap1_addr",  err_addr,  22'h3C0000);
`endif
        err_seq(22'h380000, 1'b0);
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("cap2_valid", err_valid, 1'b1);
        chk("cap2_addr",  err_addr,  22'h3C0000);
`endif
        err_seq(22'h000200, 1'b1);
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("cap3_valid", err_valid, 1'b1);
        chk("cap3_addr",  err_addr,  22'h000200);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("clr_valid", err_valid, 1'b0);
`endif

        // BUSY to the default slave: zero-wait OKAY.
        drv(1'b1, c_BUSY, 22'h3C0000, 1'b1);
        #1;
        chk("busy_ready0", HREADYOUTS, 1'b1);
        tick();
        #1;
        chk("busy_ready", HREADYOUTS, 1'b1);
        chk("busy_resp",  HRESPS,     2'b00);

        // Default-slave NONSEQ with HREADYS=0 must not start an error.
        drv(1'b1, c_NONSEQ, 22'h3C0000, 1'b0);
        tick();
        tick();
        chk("nordy_ready", HREADYOUTS, 1'b1);
        chk("nordy_resp",  HRESPS,     2'b00);
        drv(1'b0, c_IDLE, 22'h3C0000, 1'b1);
        tick();
        chk("nordy_resp2", HRESPS, 2'b00);

        // Back-to-back errors: ERR2 restarts into ERR1.
        drv(1'b1, c_NONSEQ, 22'h3C0000, 1'b1);
        tick();
        drv(1'b1, c_IDLE, 22'h3C0000, 1'b0);
        #1;
        chk("b2b_err1_ready", HREADYOUTS, 1'b0);
        tick();
        drv(1'b1, c_NONSEQ, 22'h3C0000, 1'b1);
        #1;
        chk("b2b_err2_resp", HRESPS, 2'b01);
        tick();
        drv(1'b1, c_IDLE, 22'h3C0000, 1'b0);
        #1;
        chk("b2b_again_ready", HREADYOUTS, 1'b0);
        chk("b2b_again_resp",  HRESPS,     2'b01);
        tick();
        drv(1'b1, c_IDLE, 22'h3C0000, 1'b1);
        tick();
        chk("b2b_done_resp", HRESPS, 2'b00);

        // Reset in ERR1 abandons the error sequence.
        drv(1'b1, c_NONSEQ, 22'h3C0000, 1'b1);
        tick();
        drv(1'b0, c_IDLE, 22'h0, 1'b0);
        #1;
        chk("rst_err1_ready", HREADYOUTS, 1'b0);
        HRESETn = 1'b0;
        #1;
        chk("arst_ready", HREADYOUTS, 1'b1);
        chk("arst_resp",  HRESPS,     2'b00);
        chk("arst_rdata", HRDATAS,    32'hA0A0_0000);
`ifdef CMSDK_DECODER_ERR_CAPTURE_EN
        chk("arst_err_valid", err_valid, 1'b0);
`endif
        tick();
        HRESETn = 1'b1;
        drv(1'b0, c_IDLE, 22'h0, 1'b1);
        tick();
        chk("post_rst_ready", HREADYOUTS, 1'b1);
        chk("post_rst_resp",  HRESPS,     2'b00);
        tick();
        chk("post_rst_resp2", HRESPS, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
